sgmii_link_ctrl: RTL and testbench
==================================

Name: sgmii_link_ctrl

Overview:
Link sequencer for one sgmii_tbi instance on the 125 MHz core clock. It holds the TBI block in reset until both SerDes sides report ready, then waits for autonegotiation. It decodes config_reg into link, speed and duplex, and restarts on timeout, link loss or software request. It also gates the MAC-side GMII transmit stream so that only whole frames reach sgmii_tbi while the link is up.

Parameters:
RST_HOLD, 16, cycles sgmii_rst is held high on every (re)start, minimum 2
AN_TIMEOUT, 1250000, cycles allowed in AN_WAIT before restart (10 ms)
BACKOFF, 125000, cycles spent in LINK_DOWN before restart (1 ms)
CNT_W, 21, timer width; must hold max(AN_TIMEOUT, BACKOFF, RST_HOLD)

Ports:
clk_125mhz  in  1  core clock
rst  in  1  asynchronous reset, active-high
enable  in  1  0 forces RESET_HOLD and holds it there
restart  in  1  single-cycle pulse; forces RESET_HOLD from any state
tbi_tx_rdy  in  1  TX SerDes ready
tbi_rx_rdy  in  1  RX SerDes ready
autoneg_complete  in  1  from sgmii_tbi
config_reg  in  16  partner SGMII config word: [15] link, [12] duplex, [11:10] speed
sgmii_rst  out  1  reset to sgmii_tbi
link_up  out  1  link usable
speed  out  2  00=10M, 01=100M, 10=1000M; valid while link_up
full_duplex  out  1  valid while link_up
an_timeouts  out  8  saturating count of AN timeouts
mac_txd / mac_tx_en / mac_tx_err  in  8/1/1  MAC transmit
gmii_txd / gmii_tx_en / gmii_tx_err  out  8/1/1  to sgmii_tbi gmii_tx*

Behaviour:
- Reset values: sgmii_rst=1, link_up=0, speed=00, full_duplex=0, an_timeouts=0, gmii_tx_en=0, gmii_tx_err=0, gmii_txd=0. The FSM resets to RESET_HOLD with the timer at 0.
- RESET_HOLD: sgmii_rst=1 and the timer counts. Move to WAIT_RDY once timer == RST_HOLD-1 and enable=1.
- WAIT_RDY: sgmii_rst=0. Move to AN_WAIT when tbi_tx_rdy & tbi_rx_rdy; the timer clears on entry. No timeout applies in this state.
- AN_WAIT:
  - If autoneg_complete & config_reg[15] & config_reg[11:10] != 11, move to LINK_UP and latch speed and duplex.
  - Else if timer == AN_TIMEOUT-1, increment an_timeouts (saturating at 255) and go to RESET_HOLD.
  - A speed field of 11 is reserved and is treated as not complete.
- LINK_UP: link_up=1. Any of the following moves to LINK_DOWN:
  - autoneg_complete falls;
  - config_reg[15] falls;
  - either rdy input falls;
  - the speed or duplex field changes.
- LINK_DOWN: link_up=0 and speed/duplex keep their last values. Go to RESET_HOLD after BACKOFF cycles.
- Precedence: restart or enable=0 wins over every other transition in the same cycle. These always go to RESET_HOLD with the timer cleared, including mid-frame and mid-autonegotiation.
- link_up is registered; it asserts on the cycle after the state register enters LINK_UP.
- TX gate (1-cycle registered latency, data passes when open):
  - The gate opens only on a cycle where link_up=1 and mac_tx_en=0. A frame already in progress when the link comes up is dropped entirely.
  - On link loss while mac_tx_en=1, pass the frame through to its end with gmii_tx_err=1. The gate closes when mac_tx_en falls.
  - While closed, gmii_tx_en=0, gmii_tx_err=0 and gmii_txd=0.

Optional Feature:
SGMII_LINK_STATS_EN
- Defined: adds output link_drops[15:0], a saturating count of LINK_UP→LINK_DOWN transitions. It resets to 0 and is not cleared by restart.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package sgmii_pkg: FSM state enum {RESET_HOLD, WAIT_RDY, AN_WAIT, LINK_UP, LINK_DOWN}, speed encodings SPD_10/SPD_100/SPD_1000, and config_reg bit positions CFG_LINK=15, CFG_DUPLEX=12, CFG_SPD_HI=11, CFG_SPD_LO=10.
- One sub-module, sgmii_tx_gate: frame-boundary gating and error forcing; inputs link_up and mac_tx*, outputs gmii_tx*.

Test Plan:
- Bring-up: rdy inputs high at cycle 5, autoneg_complete with config_reg=16'h9800 at cycle 40 → sgmii_rst falls at cycle 16, link_up=1, speed=10, full_duplex=1.
- AN timeout (AN_TIMEOUT=100 override): never assert autoneg_complete → an_timeouts counts 1,2,3 with a sgmii_rst pulse of RST_HOLD cycles each time.
- Mid-frame link-up: mac_tx_en already high for a 64-byte frame when link_up rises → no gmii_tx_en for that frame; the next frame passes byte-exact, delayed 1 cycle.
- Mid-frame link loss: drop config_reg[15] at byte 20 of 64 → gmii_tx_en stays high through byte 64 with gmii_tx_err=1 from byte 21; link_up=0; RESET_HOLD entered after BACKOFF.
- Restart pulse during AN_WAIT, and enable=0 during LINK_UP → RESET_HOLD next cycle, sgmii_rst=1 held while enable=0, timer cleared.
- Reserved speed: config_reg=16'h8C00 with autoneg_complete → FSM stays in AN_WAIT until timeout; with SGMII_LINK_STATS_EN, link_drops stays 0.

Source files
------------

// File: rtl/sgmii_pkg.sv
// Shared types for the SGMII link sequencer: FSM states, speed codes, config_reg layout.
package sgmii_pkg;
  typedef enum logic [2:0] {
    RESET_HOLD,
    WAIT_RDY,
    AN_WAIT,
    LINK_UP,
    LINK_DOWN
  } link_state_e;

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;

  localparam int CFG_LINK   = 15;
  localparam int CFG_DUPLEX = 12;
  localparam int CFG_SPD_HI = 11;
  localparam int CFG_SPD_LO = 10;

  // Partner word is usable only with link set and a non-reserved speed code.
  function automatic logic cfg_valid(input logic [15:0] cfg);
    logic [1:0] spd;
    spd = cfg[CFG_SPD_HI:CFG_SPD_LO];
    return cfg[CFG_LINK] && (spd == SPD_10 || spd == SPD_100 || spd == SPD_1000);
  endfunction
endpackage

// File: rtl/sgmii_link_ctrl_if.sv
// MAC-side GMII transmit stream in, gated GMII transmit stream out toward sgmii_tbi.
interface sgmii_link_ctrl_if;
  logic [7:0] mac_txd;
  logic       mac_tx_en;
  logic       mac_tx_err;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_err;

  modport master (
    output mac_txd, mac_tx_en, mac_tx_err,
    input  gmii_txd, gmii_tx_en, gmii_tx_err
  );

  modport slave (
    input  mac_txd, mac_tx_en, mac_tx_err,
    output gmii_txd, gmii_tx_en, gmii_tx_err
  );
endinterface

// File: rtl/sgmii_tx_gate.sv
// Frame-boundary TX gate: opens only between frames while the link is up, one cycle latency.
// A frame cut by link loss runs to its end with tx_err forced.
module sgmii_tx_gate (
  input  logic       clk_125mhz,
  input  logic       rst,
  input  logic       link_up,
  input  logic [7:0] mac_txd,
  input  logic       mac_tx_en,
  input  logic       mac_tx_err,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_err
);
  logic       open_q, open_d;
  logic [7:0] txd_q, txd_d;
  logic       en_q, en_d;
  logic       err_q, err_d;

  always_comb begin
    open_d = open_q ? (link_up | mac_tx_en) : (link_up & ~mac_tx_en);
    txd_d  = '0;
    en_d   = 1'b0;
    err_d  = 1'b0;
    if (open_q) begin
      txd_d = mac_txd;
      en_d  = mac_tx_en;
      err_d = mac_tx_err | (mac_tx_en & ~link_up);
    end
  end

  always_ff @(posedge clk_125mhz or posedge rst) begin
    if (rst) begin
      open_q <= 1'b0;
      txd_q  <= '0;
      en_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      open_q <= open_d;
      txd_q  <= txd_d;
      en_q   <= en_d;
      err_q  <= err_d;
    end
  end

  assign gmii_txd    = txd_q;
  assign gmii_tx_en  = en_q;
  assign gmii_tx_err = err_q;
endmodule

// File: rtl/sgmii_link_ctrl.sv
// SGMII link sequencer: reset hold, SerDes ready wait, autoneg wait, link monitor, backoff.
// Define SGMII_LINK_STATS_EN to add the saturating link_drops counter output.
module sgmii_link_ctrl
  import sgmii_pkg::*;
#(
  parameter int RST_HOLD   = 16,
  parameter int AN_TIMEOUT = 1250000,
  parameter int BACKOFF    = 125000,
  parameter int CNT_W      = 21
) (
  input  logic              clk_125mhz,
  input  logic              rst,
  input  logic              enable,
  input  logic              restart,
  input  logic              tbi_tx_rdy,
  input  logic              tbi_rx_rdy,
  input  logic              autoneg_complete,
  input  logic [15:0]       config_reg,
  output logic              sgmii_rst,
  output logic              link_up,
  output logic [1:0]        speed,
  output logic              full_duplex,
  output logic [7:0]        an_timeouts,
`ifdef SGMII_LINK_STATS_EN
  output logic [15:0]       link_drops,
`endif
  sgmii_link_ctrl_if.slave  tx_if
);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] AN_LAST  = CNT_W'(AN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BO_LAST  = CNT_W'(BACKOFF - 1);

  link_state_e      state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       speed_q, speed_d;
  logic             duplex_q, duplex_d;
  logic [7:0]       an_to_q, an_to_d;
  logic             sgmii_rst_q, sgmii_rst_d;
  logic             link_up_q, link_up_d;
  logic             rdy;
  logic [1:0]       cfg_spd;
  logic             link_live;

  assign rdy       = tbi_tx_rdy & tbi_rx_rdy;
  assign cfg_spd   = config_reg[CFG_SPD_HI:CFG_SPD_LO];
  assign link_live = (state_q == LINK_UP);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    speed_d  = speed_q;
    duplex_d = duplex_q;
    an_to_d  = an_to_q;
    case (state_q)
      RESET_HOLD: begin
        if (timer_q == RST_LAST) begin
          if (enable) begin
            state_d = WAIT_RDY;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      WAIT_RDY: begin
        if (rdy) begin
          state_d = AN_WAIT;
          timer_d = '0;
        end
      end
      AN_WAIT: begin
        if (autoneg_complete && cfg_valid(config_reg)) begin
          state_d  = LINK_UP;
          timer_d  = '0;
          speed_d  = cfg_spd;
          duplex_d = config_reg[CFG_DUPLEX];
        end else if (timer_q == AN_LAST) begin
          state_d = RESET_HOLD;
          timer_d = '0;
          if (an_to_q != 8'hFF) an_to_d = an_to_q + 8'd1;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      LINK_UP: begin
        // Any drop of a ready/link qualifier or a renegotiated speed/duplex is a loss.
        if (!autoneg_complete || !config_reg[CFG_LINK] || !rdy ||
            cfg_spd != speed_q || config_reg[CFG_DUPLEX] != duplex_q) begin
          state_d = LINK_DOWN;
          timer_d = '0;
        end
      end
      LINK_DOWN: begin
        if (timer_q == BO_LAST) begin
          state_d = RESET_HOLD;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RESET_HOLD;
        timer_d = '0;
      end
    endcase
    if (restart || !enable) begin
      state_d  = RESET_HOLD;
      timer_d  = '0;
      speed_d  = speed_q;
      duplex_d = duplex_q;
      an_to_d  = an_to_q;
    end
    sgmii_rst_d = (state_d == RESET_HOLD);
    link_up_d   = link_live;
  end

  always_ff @(posedge clk_125mhz or posedge rst) begin
    if (rst) begin
      state_q     <= RESET_HOLD;
      timer_q     <= '0;
      speed_q     <= SPD_10;
      duplex_q    <= 1'b0;
      an_to_q     <= '0;
      sgmii_rst_q <= 1'b1;
      link_up_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      speed_q     <= speed_d;
      duplex_q    <= duplex_d;
      an_to_q     <= an_to_d;
      sgmii_rst_q <= sgmii_rst_d;
      link_up_q   <= link_up_d;
    end
  end

`ifdef SGMII_LINK_STATS_EN
  logic [15:0] drops_q, drops_d;

  always_comb begin
    drops_d = drops_q;
    if (state_q == LINK_UP && state_d == LINK_DOWN && drops_q != 16'hFFFF)
      drops_d = drops_q + 16'd1;
  end

  always_ff @(posedge clk_125mhz or posedge rst) begin
    if (rst) drops_q <= '0;
    else     drops_q <= drops_d;
  end

  assign link_drops = drops_q;
`endif

  assign sgmii_rst   = sgmii_rst_q;
  assign link_up     = link_up_q;
  assign speed       = speed_q;
  assign full_duplex = duplex_q;
  assign an_timeouts = an_to_q;

  sgmii_tx_gate u_tx_gate (
    .clk_125mhz  (clk_125mhz),
    .rst         (rst),
    .link_up     (link_live),
    .mac_txd     (tx_if.mac_txd),
    .mac_tx_en   (tx_if.mac_tx_en),
    .mac_tx_err  (tx_if.mac_tx_err),
    .gmii_txd    (tx_if.gmii_txd),
    .gmii_tx_en  (tx_if.gmii_tx_en),
    .gmii_tx_err (tx_if.gmii_tx_err)
  );
endmodule

// File: tb/tb_sgmii_link_ctrl.sv
// Directed bench for sgmii_link_ctrl with shortened AN_TIMEOUT/BACKOFF.
module tb_sgmii_link_ctrl;
  logic        clk_125mhz = 1'b0;
  logic        rst;
  logic        enable;
  logic        restart;
  logic        tbi_tx_rdy;
  logic        tbi_rx_rdy;
  logic        autoneg_complete;
  logic [15:0] config_reg;
  logic        sgmii_rst;
  logic        link_up;
  logic [1:0]  speed;
  logic        full_duplex;
  logic [7:0]  an_timeouts;
`ifdef SGMII_LINK_STATS_EN
  logic [15:0] link_drops;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  sgmii_link_ctrl_if tx_if ();

  sgmii_link_ctrl #(
    .RST_HOLD   (16),
    .AN_TIMEOUT (100),
    .BACKOFF    (50),
    .CNT_W      (21)
  ) dut (
    .clk_125mhz       (clk_125mhz),
    .rst              (rst),
    .enable           (enable),
    .restart          (restart),
    .tbi_tx_rdy       (tbi_tx_rdy),
    .tbi_rx_rdy       (tbi_rx_rdy),
    .autoneg_complete (autoneg_complete),
    .config_reg       (config_reg),
    .sgmii_rst        (sgmii_rst),
    .link_up          (link_up),
    .speed            (speed),
    .full_duplex      (full_duplex),
    .an_timeouts      (an_timeouts),
`ifdef SGMII_LINK_STATS_EN
    .link_drops       (link_drops),
`endif
    .tx_if            (tx_if)
  );

  always #4 clk_125mhz = ~clk_125mhz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_125mhz);
    #1;
  endtask

  // RESET_HOLD lasts 16 cycles from a cleared timer, then sgmii_rst drops.
  task automatic check_hold(input string tag);
    repeat (15) tick();
    chk({tag, "_rst_hi"}, sgmii_rst, 1);
    tick();
    chk({tag, "_rst_lo"}, sgmii_rst, 0);
  endtask

  // One frame of len bytes, data = seed+i; config_reg[15] clears with byte index drop_at.
  task automatic drive_frame(input string tag, input int len, input logic [7:0] seed,
                             input bit exp_pass, input int drop_at);
    for (int i = 0; i < len; i++) begin
      tx_if.mac_txd   = seed + 8'(i);
      tx_if.mac_tx_en = 1'b1;
      if (i == drop_at) config_reg[15] = 1'b0;
      tick();
      chk({tag, "_en"}, tx_if.gmii_tx_en, exp_pass);
      chk({tag, "_txd"}, tx_if.gmii_txd, exp_pass ? 32'(seed + 8'(i)) : 32'd0);
      chk({tag, "_err"}, tx_if.gmii_tx_err, (exp_pass && drop_at >= 0 && i > drop_at) ? 1 : 0);
    end
    tx_if.mac_tx_en = 1'b0;
    tx_if.mac_txd   = 8'h00;
    tick();
    chk({tag, "_idle_en"}, tx_if.gmii_tx_en, 0);
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    restart = 1'b0;
    tbi_tx_rdy = 1'b0;
    tbi_rx_rdy = 1'b0;
    autoneg_complete = 1'b0;
    config_reg = 16'h0000;
    tx_if.mac_txd = 8'h00;
    tx_if.mac_tx_en = 1'b0;
    tx_if.mac_tx_err = 1'b0;
    #20;
    chk("rst_sgmii_rst", sgmii_rst, 1);
    chk("rst_link_up", link_up, 0);
    chk("rst_speed", speed, 0);
    chk("rst_duplex", full_duplex, 0);
    chk("rst_an_to", an_timeouts, 0);
    chk("rst_tx_en", tx_if.gmii_tx_en, 0);
    chk("rst_tx_err", tx_if.gmii_tx_err, 0);
    chk("rst_txd", tx_if.gmii_txd, 0);
    @(posedge clk_125mhz);
    #1 rst = 1'b0;

    // Bring-up: rdy at cycle 5, autoneg with 1000M full duplex at cycle 40.
    for (int cyc = 1; cyc <= 41; cyc++) begin
      if (cyc == 5) begin
        tbi_tx_rdy = 1'b1;
        tbi_rx_rdy = 1'b1;
      end
      if (cyc == 40) begin
        autoneg_complete = 1'b1;
        config_reg = 16'h9800;
      end
      tick();
      if (cyc == 15) chk("up_rst_c15", sgmii_rst, 1);
      if (cyc == 16) chk("up_rst_c16", sgmii_rst, 0);
      if (cyc == 40) chk("up_link_c40", link_up, 0);
      if (cyc == 41) begin
        chk("up_link_c41", link_up, 1);
        chk("up_speed", speed, 2'b10);
        chk("up_duplex", full_duplex, 1);
      end
    end

    // Link loss at byte 20 of 64: frame completes with err from byte 21.
    drive_frame("loss", 64, 8'h10, 1'b1, 19);
    chk("loss_link_up", link_up, 0);
    chk("loss_speed_kept", speed, 2'b10);
    chk("loss_duplex_kept", full_duplex, 1);
    config_reg = 16'h9800;
    repeat (4) tick();
    chk("backoff_49", sgmii_rst, 0);
    tick();
    chk("backoff_50", sgmii_rst, 1);

    // Frame already running when the link comes back is dropped; next one passes.
    drive_frame("midup", 64, 8'h40, 1'b0, -1);
    chk("midup_link_up", link_up, 1);
    drive_frame("pass", 64, 8'h80, 1'b1, -1);

    // enable=0 during LINK_UP holds reset; re-enable needs a full hold time.
    enable = 1'b0;
    tick();
    chk("dis_rst_next", sgmii_rst, 1);
    tick();
    chk("dis_link_up", link_up, 0);
    repeat (30) tick();
    chk("dis_rst_held", sgmii_rst, 1);
    autoneg_complete = 1'b0;
    enable = 1'b1;
    check_hold("reen");

    // Restart pulse in AN_WAIT.
    tick();
    repeat (5) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rs_rst_next", sgmii_rst, 1);
    check_hold("rs");
    chk("rs_an_to", an_timeouts, 0);

    // Three AN timeouts, then a fourth with the reserved speed code.
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) begin
        autoneg_complete = 1'b1;
        config_reg = 16'h8C00;
      end
      repeat (100) tick();
      chk("to_rst_before", sgmii_rst, 0);
      chk("to_cnt_before", an_timeouts, k - 1);
      if (k == 4) chk("rsvd_link_up", link_up, 0);
      tick();
      chk("to_rst_after", sgmii_rst, 1);
      chk("to_cnt_after", an_timeouts, k);
      check_hold("to");
    end
`ifdef SGMII_LINK_STATS_EN
    chk("stats_drops", link_drops, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
